// File: rtl/count_uart_pkg.sv
// Shared types and constants for the counter-value UART transmitter.
// Frame layout: one start bit, DATA_BITS data bits (LSB first), one stop bit.
package count_uart_pkg;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = FRAME_BITS - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/count_fifo.sv
// Synchronous byte FIFO with an occupancy counter; rd_data shows the head entry.
// Writes while full and reads while empty are ignored.
module count_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             push;
  logic             pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage needs no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/count_uart_tx.sv
// Queues counter bytes in a small FIFO and sends each as an 8N1 UART frame on tx.
// Frames are chained back-to-back while the FIFO holds data.
//
//   state | meaning
//   IDLE  | line high, waiting for a queued byte
//   START | driving the start bit (0)
//   DATA  | shifting out data bits, LSB first
//   STOP  | driving the stop bit (1); chains to START if more data is queued
module count_uart_tx
  import count_uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          clr_ovf,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam logic [7:0] BAUD_LAST = 8'(CLK_DIV - 1);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);

  uart_state_e state_q, state_d;
  logic [7:0]  baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        ovf_q;

  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_head;
  logic        bit_end;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign bit_end  = (baud_q == 8'd0);
  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);
  assign overflow = ovf_q;

  count_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          tx_d    = 1'b0;
          baud_d  = BAUD_LAST;
          state_d = START;
        end
      end

      START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          bit_d   = 3'd0;
          baud_d  = BAUD_LAST;
          state_d = DATA;
        end else begin
          baud_d = baud_q - 8'd1;
        end
      end

      DATA: begin
        if (bit_end) begin
          baud_d = BAUD_LAST;
          if (bit_q == LAST_DATA) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q - 8'd1;
        end
      end

      STOP: begin
        if (bit_end) begin
          // Chain the next frame immediately so there is no idle gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            tx_d    = 1'b0;
            baud_d  = BAUD_LAST;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - 8'd1;
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= 8'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // A rejected offer in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (in_valid && !in_ready) begin
      ovf_q <= 1'b1;
    end else if (clr_ovf) begin
      ovf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_count_uart_tx.sv
// Self-checking bench for count_uart_tx: fixed frame/overflow tables, reset abort,
// and randomized traffic against a queue-based frame model, at CLK_DIV 4 and 2.
module tb_count_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       v4 = 1'b0, c4 = 1'b0, v2 = 1'b0, c2 = 1'b0;
  logic [7:0] d4 = 8'h00, d2 = 8'h00;
  logic       rdy4, tx4, busy4, ovf4;
  logic       rdy2, tx2, busy2, ovf2;
  logic [2:0] lvl4, lvl2;

  int         cur = 0;
  logic       rdy_s, tx_s, busy_s, ovf_s;
  logic [2:0] lvl_s;

  int n_checks = 0;
  int n_fail   = 0;

  count_uart_tx #(.CLK_DIV(4), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(d4), .in_valid(v4), .in_ready(rdy4),
    .clr_ovf(c4), .tx(tx4), .busy(busy4), .overflow(ovf4), .fifo_level(lvl4)
  );

  count_uart_tx #(.CLK_DIV(2), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(d2), .in_valid(v2), .in_ready(rdy2),
    .clr_ovf(c2), .tx(tx2), .busy(busy2), .overflow(ovf2), .fifo_level(lvl2)
  );

  always #5 clk = ~clk;

  assign rdy_s  = (cur == 1) ? rdy2  : rdy4;
  assign tx_s   = (cur == 1) ? tx2   : tx4;
  assign busy_s = (cur == 1) ? busy2 : busy4;
  assign ovf_s  = (cur == 1) ? ovf2  : ovf4;
  assign lvl_s  = (cur == 1) ? lvl2  : lvl4;

  // Reference model: byte queue plus the active frame as a 10-bit line pattern.
  logic [7:0] mq[$];
  bit         m_act;
  int         m_pos;
  logic [9:0] m_frame;
  bit         m_ovf;

  function automatic int m_div();
    return (cur == 1) ? 2 : 4;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_act = 0;
    m_pos = 0;
    m_frame = '1;
    m_ovf = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic c);
    bit full;
    full = (mq.size() == 4);
    if (m_act) begin
      m_pos++;
      if (m_pos == 10 * m_div()) m_act = 0;
    end
    if (!m_act && mq.size() > 0) begin
      m_frame = {1'b1, mq.pop_front(), 1'b0};
      m_pos = 0;
      m_act = 1;
    end
    if (v && !full) mq.push_back(d);
    if (v && full) m_ovf = 1;
    else if (c) m_ovf = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (dut sel %0d, t=%0t)", name, act, exp_v, cur, $time);
    end
  endtask

  task automatic compare_model();
    logic exp_tx;
    exp_tx = m_act ? m_frame[m_pos / m_div()] : 1'b1;
    check("tx", 32'(tx_s), 32'(exp_tx));
    check("busy", 32'(busy_s), 32'(m_act));
    check("fifo_level", 32'(lvl_s), 32'(mq.size()));
    check("in_ready", 32'(rdy_s), 32'(mq.size() != 4));
    check("overflow", 32'(ovf_s), 32'(m_ovf));
  endtask

  task automatic tick(input logic v, input logic [7:0] d, input logic c);
    if (cur == 0) begin v4 = v; d4 = d; c4 = c; end
    else begin v2 = v; d2 = d; c2 = c; end
    @(posedge clk);
    model_step(v, d, c);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    v4 = 0; c4 = 0; v2 = 0; c2 = 0;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic [9:0] line;
  } frame_vec_t;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       c;
    logic       rdy;
    logic       ovf;
    int         lvl;
  } ovf_vec_t;

  frame_vec_t fvt[3];
  ovf_vec_t   ovt[9];

  // Pushes n table bytes on consecutive cycles, then checks every bit period.
  task automatic run_frames(input int first, input int n);
    int nxt;
    int div;
    cur = fvt[first].sel;
    div = m_div();
    tick(1'b1, fvt[first].data, 1'b0);
    nxt = first + 1;
    for (int f = first; f < first + n; f++) begin
      for (int b = 0; b < 10; b++) begin
        for (int j = 0; j < div; j++) begin
          if (nxt < first + n) begin
            tick(1'b1, fvt[nxt].data, 1'b0);
            nxt++;
          end else begin
            tick(1'b0, 8'h00, 1'b0);
          end
          check("frame_tx", 32'(tx_s), 32'(fvt[f].line[b]));
          check("frame_busy", 32'(busy_s), 32'd1);
        end
      end
    end
    tick(1'b0, 8'h00, 1'b0);
    check("after_frame_tx", 32'(tx_s), 32'd1);
    check("after_frame_busy", 32'(busy_s), 32'd0);
  endtask

  initial begin
    int busy_cnt;
    int falls;
    logic prev_busy;

    fvt[0] = '{0, 8'hA5, 10'b1101001010};
    fvt[1] = '{1, 8'h00, 10'b1000000000};
    fvt[2] = '{1, 8'hFF, 10'b1111111110};

    ovt[0] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1};
    ovt[1] = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 1};
    ovt[2] = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 2};
    ovt[3] = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 3};
    ovt[4] = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b0, 4};
    ovt[5] = '{1'b1, 8'h06, 1'b0, 1'b0, 1'b1, 4};
    ovt[6] = '{1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 4};
    ovt[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4};
    ovt[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4};

    model_reset();

    // Reset state, with an offer that must be ignored
    cur = 0;
    v4 = 1; d4 = 8'h3C;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx", 32'(tx4), 32'd1);
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_ovf", 32'(ovf4), 32'd0);
    check("rst_level", 32'(lvl4), 32'd0);
    check("rst_in_ready", 32'(rdy4), 32'd1);
    check("rst_tx_div2", 32'(tx2), 32'd1);
    v4 = 0;
    @(negedge clk);
    rst_n = 1;
    tick(1'b0, 8'h00, 1'b0);

    // Single 0xA5 frame at CLK_DIV=4
    run_frames(0, 1);

    // Overflow table, then the five queued frames back-to-back
    cur = 0;
    do_reset();
    busy_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      check("ovt_in_ready", 32'(rdy_s), 32'(ovt[i].rdy));
      tick(ovt[i].v, ovt[i].d, ovt[i].c);
      check("ovt_overflow", 32'(ovf_s), 32'(ovt[i].ovf));
      check("ovt_level", 32'(lvl_s), 32'(ovt[i].lvl));
      busy_cnt += int'(busy_s);
    end
    falls = 0;
    prev_busy = busy_s;
    for (int i = 0; i < 400 && busy_s; i++) begin
      tick(1'b0, 8'h00, 1'b0);
      busy_cnt += int'(busy_s);
      if (prev_busy && !busy_s) falls++;
      prev_busy = busy_s;
    end
    check("burst_busy_cycles", 32'(busy_cnt), 32'd200);
    check("burst_busy_falls", 32'(falls), 32'd1);
    check("burst_level_end", 32'(lvl_s), 32'd0);

    // Reset in the middle of a data bit of the second queued frame
    cur = 0;
    do_reset();
    tick(1'b1, 8'h3C, 1'b0);
    tick(1'b1, 8'h5A, 1'b0);
    tick(1'b1, 8'h77, 1'b0);
    repeat (53) tick(1'b0, 8'h00, 1'b0);
    check("pre_abort_busy", 32'(busy_s), 32'd1);
    check("pre_abort_level", 32'(lvl_s), 32'd1);
    #2;
    rst_n = 0;
    #1;
    check("abort_tx", 32'(tx4), 32'd1);
    check("abort_busy", 32'(busy4), 32'd0);
    check("abort_level", 32'(lvl4), 32'd0);
    check("abort_in_ready", 32'(rdy4), 32'd1);
    v4 = 1; d4 = 8'hEE;
    repeat (2) @(posedge clk);
    #1;
    check("abort_push_ignored", 32'(lvl4), 32'd0);
    v4 = 0;
    @(negedge clk);
    rst_n = 1;
    model_reset();
    busy_cnt = 0;
    repeat (100) begin
      tick(1'b0, 8'h00, 1'b0);
      busy_cnt += int'(busy_s);
    end
    check("abort_no_more_frames", 32'(busy_cnt), 32'd0);

    // 0x00 then 0xFF at CLK_DIV=2
    cur = 1;
    do_reset();
    run_frames(1, 2);

    // Randomized traffic on both instances
    for (int s = 0; s < 2; s++) begin
      cur = s;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
        tick(($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 15) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
